// File: rtl/ysyx_041461_pipe_skid_reg.sv
// Valid/ready pipeline register with a 2-entry skid buffer.
// Registered in_ready, synchronous flush and a saturating stall counter.
module ysyx_041461_pipe_skid_reg #(
  parameter int PC_W = 64,
  parameter int DATA_W = 64,
  parameter int WAYS = 8,
  parameter int TRAP_W = 4,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(64'h3000_0000),
  parameter logic [TRAP_W-1:0] TRAP_RST = '0,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [WAYS-1:0]   in_hit,
  input  logic [TRAP_W-1:0] in_trap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [WAYS-1:0]   out_hit,
  output logic [TRAP_W-1:0] out_trap,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b10;
  localparam logic [1:0] FULL  = 2'b11;

  logic              main_valid;
  logic              skid_valid;
  logic [PC_W-1:0]   skid_pc;
  logic [DATA_W-1:0] skid_data;
  logic [WAYS-1:0]   skid_hit;
  logic [TRAP_W-1:0] skid_trap;

  logic       in_fire;
  logic       out_fire;
  logic [1:0] state;
  logic       load_in;
  logic       load_skid;
  logic       load_from_skid;
  logic       nxt_main_valid;
  logic       nxt_skid_valid;

  assign in_ready  = ~skid_valid;
  assign out_valid = main_valid;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = main_valid & out_ready;
  assign state     = {main_valid, skid_valid};

  always_comb begin
    load_in        = 1'b0;
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
    nxt_main_valid = main_valid;
    nxt_skid_valid = skid_valid;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          load_in        = 1'b1;
          nxt_main_valid = 1'b1;
        end
      end
      ONE: begin
        if (in_fire & out_fire) begin
          load_in = 1'b1;
        end else if (out_fire) begin
          nxt_main_valid = 1'b0;
        end else if (in_fire) begin
          load_skid      = 1'b1;
          nxt_skid_valid = 1'b1;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_from_skid = 1'b1;
          nxt_skid_valid = 1'b0;
        end
      end
      default: begin
        nxt_main_valid = 1'b0;
        nxt_skid_valid = 1'b0;
      end
    endcase
    // Flush wins over every handshake; a beat offered alongside it is dropped.
    if (flush) begin
      load_in        = 1'b0;
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
      nxt_main_valid = 1'b0;
      nxt_skid_valid = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      main_valid <= nxt_main_valid;
      skid_valid <= nxt_skid_valid;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_pc   <= RESET_PC;
      out_data <= '0;
      out_hit  <= '0;
      out_trap <= TRAP_RST;
    end else if (flush) begin
      out_trap <= TRAP_RST;
    end else if (load_in) begin
      out_pc   <= in_pc;
      out_data <= in_data;
      out_hit  <= in_hit;
      out_trap <= in_trap;
    end else if (load_from_skid) begin
      out_pc   <= skid_pc;
      out_data <= skid_data;
      out_hit  <= skid_hit;
      out_trap <= skid_trap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_pc   <= '0;
      skid_data <= '0;
      skid_hit  <= '0;
      skid_trap <= '0;
    end else if (load_skid) begin
      skid_pc   <= in_pc;
      skid_data <= in_data;
      skid_hit  <= in_hit;
      skid_trap <= in_trap;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (main_valid & ~out_ready & ~(&stall_cnt)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ysyx_041461_pipe_skid_reg.sv
// Bench for ysyx_041461_pipe_skid_reg: directed table, corner sequences
// and a randomised scoreboard run.
module tb_ysyx_041461_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pc;
  logic [63:0] in_data;
  logic [7:0]  in_hit;
  logic [3:0]  in_trap;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [63:0] out_data;
  logic [7:0]  out_hit;
  logic [3:0]  out_trap;
  logic [3:0]  stall_cnt;

  always #5 clk = ~clk;

  ysyx_041461_pipe_skid_reg #(.CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_data(in_data), .in_hit(in_hit), .in_trap(in_trap),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_data(out_data), .out_hit(out_hit),
    .out_trap(out_trap), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [63:0] pc);
    return pc ^ 64'hDEAD_BEEF_0000_0000;
  endfunction
  function automatic logic [7:0] hit_of(input logic [63:0] pc);
    return pc[9:2];
  endfunction
  function automatic logic [3:0] trap_of(input logic [63:0] pc);
    return pc[5:2] ^ 4'h9;
  endfunction

  task automatic drive(input logic fl, input logic iv,
                       input logic [63:0] pc, input logic ordy);
    flush     = fl;
    in_valid  = iv;
    in_pc     = pc;
    in_data   = data_of(pc);
    in_hit    = hit_of(pc);
    in_trap   = trap_of(pc);
    out_ready = ordy;
  endtask

  typedef struct {
    logic        fl;
    logic        iv;
    logic [63:0] ipc;
    logic        ordy;
    logic        ov;
    logic        ir;
    logic [63:0] opc;
    logic [3:0]  otrap;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl[21];

  typedef struct {
    logic [63:0] pc;
    logic [63:0] data;
    logic [7:0]  hit;
    logic [3:0]  trap;
  } beat_t;

  beat_t sb[$];
  beat_t nb;
  beat_t got;

  localparam int NBEATS = 10000;

  initial begin
    // inputs applied this cycle | state observed before the next edge
    tbl[0]  = '{0, 1, 64'h100, 1, 0, 1, 64'h3000_0000, 4'h0, 4'd0};
    tbl[1]  = '{0, 1, 64'h104, 1, 1, 1, 64'h100, 4'h9, 4'd0};
    tbl[2]  = '{0, 1, 64'h108, 1, 1, 1, 64'h104, 4'h8, 4'd0};
    tbl[3]  = '{0, 0, 64'h0,   1, 1, 1, 64'h108, 4'hB, 4'd0};
    tbl[4]  = '{0, 0, 64'h0,   1, 0, 1, 64'h108, 4'hB, 4'd0};
    tbl[5]  = '{0, 1, 64'h200, 0, 0, 1, 64'h108, 4'hB, 4'd0};
    tbl[6]  = '{0, 1, 64'h204, 0, 1, 1, 64'h200, 4'h9, 4'd0};
    tbl[7]  = '{0, 1, 64'h208, 0, 1, 0, 64'h200, 4'h9, 4'd1};
    tbl[8]  = '{0, 0, 64'h0,   0, 1, 0, 64'h200, 4'h9, 4'd2};
    tbl[9]  = '{0, 0, 64'h0,   1, 1, 0, 64'h200, 4'h9, 4'd3};
    tbl[10] = '{0, 0, 64'h0,   1, 1, 1, 64'h204, 4'h8, 4'd3};
    tbl[11] = '{0, 0, 64'h0,   1, 0, 1, 64'h204, 4'h8, 4'd3};
    tbl[12] = '{0, 1, 64'h280, 0, 0, 1, 64'h204, 4'h8, 4'd3};
    tbl[13] = '{0, 1, 64'h284, 0, 1, 1, 64'h280, 4'h9, 4'd3};
    tbl[14] = '{1, 1, 64'h300, 0, 1, 0, 64'h280, 4'h9, 4'd4};
    tbl[15] = '{0, 0, 64'h0,   1, 0, 1, 64'h280, 4'h0, 4'd5};
    tbl[16] = '{1, 1, 64'h304, 1, 0, 1, 64'h280, 4'h0, 4'd5};
    tbl[17] = '{0, 0, 64'h0,   1, 0, 1, 64'h280, 4'h0, 4'd5};
    tbl[18] = '{0, 1, 64'h400, 1, 0, 1, 64'h280, 4'h0, 4'd5};
    tbl[19] = '{1, 0, 64'h0,   1, 1, 1, 64'h400, 4'h9, 4'd5};
    tbl[20] = '{0, 0, 64'h0,   1, 0, 1, 64'h400, 4'h0, 4'd5};

    rst = 1'b1;
    drive(0, 0, 64'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset in_ready", 64'(in_ready), 64'd1);
    chk("reset out_pc", out_pc, 64'h3000_0000);
    chk("reset out_trap", 64'(out_trap), 64'd0);
    chk("reset stall_cnt", 64'(stall_cnt), 64'd0);
    rst = 1'b0;

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i].fl, tbl[i].iv, tbl[i].ipc, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", i), 64'(out_valid), 64'(tbl[i].ov));
      chk($sformatf("vec%0d in_ready", i), 64'(in_ready), 64'(tbl[i].ir));
      chk($sformatf("vec%0d out_pc", i), out_pc, tbl[i].opc);
      chk($sformatf("vec%0d out_trap", i), 64'(out_trap), 64'(tbl[i].otrap));
      chk($sformatf("vec%0d stall_cnt", i), 64'(stall_cnt), 64'(tbl[i].cnt));
      if (tbl[i].ov) begin
        chk($sformatf("vec%0d out_data", i), out_data, data_of(tbl[i].opc));
        chk($sformatf("vec%0d out_hit", i), 64'(out_hit), 64'(hit_of(tbl[i].opc)));
      end
      @(posedge clk);
      #1;
    end

    // Saturation: fill both entries, then stall well past 15 cycles.
    drive(0, 1, 64'h500, 0);
    @(posedge clk); #1;
    drive(0, 1, 64'h504, 0);
    @(posedge clk); #1;
    drive(0, 0, 64'h0, 0);
    repeat (18) @(posedge clk);
    #1;
    chk("sat stall_cnt", 64'(stall_cnt), 64'd15);
    chk("sat in_ready", 64'(in_ready), 64'd0);
    chk("sat out_pc", out_pc, 64'h500);
    @(posedge clk); #1;
    chk("sat stall_cnt hold", 64'(stall_cnt), 64'd15);

    // Asynchronous reset between edges while FULL.
    #2;
    rst = 1'b1;
    #1;
    chk("arst out_valid", 64'(out_valid), 64'd0);
    chk("arst in_ready", 64'(in_ready), 64'd1);
    chk("arst out_pc", out_pc, 64'h3000_0000);
    chk("arst out_data", out_data, 64'd0);
    chk("arst out_hit", 64'(out_hit), 64'd0);
    chk("arst out_trap", 64'(out_trap), 64'd0);
    chk("arst stall_cnt", 64'(stall_cnt), 64'd0);
    #1;
    rst = 1'b0;
    drive(0, 0, 64'h0, 1);
    @(posedge clk); #1;
    chk("arst beats discarded", 64'(out_valid), 64'd0);

    // Random valid/ready with scoreboard.
    begin
      int sent = 0;
      int rcvd = 0;
      int cyc = 0;
      nb.pc   = 64'h8000_0000;
      nb.hit  = 8'($urandom);
      nb.data = nb.pc ^ 64'(nb.hit);
      nb.trap = 4'($urandom);
      while (rcvd < NBEATS && cyc < 60000) begin
        flush     = 1'b0;
        in_valid  = (sent < NBEATS) && ($urandom_range(3) != 0);
        in_pc     = nb.pc;
        in_data   = nb.data;
        in_hit    = nb.hit;
        in_trap   = nb.trap;
        out_ready = ($urandom_range(3) != 0);
        @(negedge clk);
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("rand spurious beat", out_pc, 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            got = sb.pop_front();
            chk("rand pc", out_pc, got.pc);
            chk("rand data", out_data, got.data);
            chk("rand hit_trap", 64'({out_hit, out_trap}), 64'({got.hit, got.trap}));
          end
          rcvd++;
        end
        if (in_valid && in_ready) begin
          sb.push_back(nb);
          sent++;
          nb.pc   = nb.pc + 64'd4;
          nb.hit  = 8'($urandom);
          nb.data = nb.pc ^ 64'(nb.hit);
          nb.trap = 4'($urandom);
        end
        @(posedge clk); #1;
        cyc++;
      end
      chk("rand beats received", 64'(rcvd), 64'(NBEATS));
      chk("rand scoreboard empty", 64'(sb.size()), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
